// File: rtl/shftmult_seq.sv
// Sequential signed shift-add multiplier with start/ready handshake.
// Iterates once per cycle over the magnitude of the multiplier, then applies
// the sign and reports the low product word plus a signed-overflow flag.
module shftmult_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             ready,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CW-1:0]    ct, ct_next;
    logic [PW-1:0]    acc, acc_next;
    logic [PW-1:0]    mcand, mcand_next;
    logic [WIDTH-1:0] mplier, mplier_next;
    logic             neg, neg_next;
    logic [WIDTH-1:0] result_next;
    logic             exception_next;
    logic             ready_next;
    logic             busy_next;

    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [PW-1:0]    acc_sum_c;
    logic [PW-1:0]    prod_c;
    logic [WIDTH:0]   prod_top_c;

    // Operand magnitudes; the most negative value maps onto itself as unsigned.
    assign a_mag_c = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
    assign b_mag_c = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;

    // Accumulator after the current iteration and the signed final product.
    assign acc_sum_c  = mplier[0] ? (acc + mcand) : acc;
    assign prod_c     = neg ? (~acc_sum_c + PW'(1)) : acc_sum_c;
    assign prod_top_c = prod_c[PW-1:WIDTH-1];

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ct        <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            neg       <= 1'b0;
            result    <= '0;
            exception <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            ct        <= ct_next;
            acc       <= acc_next;
            mcand     <= mcand_next;
            mplier    <= mplier_next;
            neg       <= neg_next;
            result    <= result_next;
            exception <= exception_next;
            ready     <= ready_next;
            busy      <= busy_next;
        end
    end

    // Next-state, iteration step and registered-output next values.
    always_comb begin
        state_next     = state;
        ct_next        = ct;
        acc_next       = acc;
        mcand_next     = mcand;
        mplier_next    = mplier;
        neg_next       = neg;
        result_next    = result;
        exception_next = exception;
        ready_next     = 1'b0;
        busy_next      = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (ctrl) begin
                    state_next  = RUN;
                    ct_next     = '0;
                    acc_next    = '0;
                    mcand_next  = PW'(a_mag_c);
                    mplier_next = b_mag_c;
                    neg_next    = A[WIDTH-1] ^ B[WIDTH-1];
                    busy_next   = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                acc_next    = acc_sum_c;
                mcand_next  = mcand << 1;
                mplier_next = mplier >> 1;
                ct_next     = ct + CW'(1);
                if (ct == CW'(WIDTH - 1)) begin
                    state_next     = DONE;
                    result_next    = prod_c[WIDTH-1:0];
                    exception_next = ~((&prod_top_c) | ~(|prod_top_c));
                    ready_next     = 1'b1;
                end else begin
                    busy_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/shftmult_seq.md
Name: shftmult_seq

Overview:
- Sequential signed 32x32 shift-add multiplier for the multdiv unit; the multiply counterpart of the shift-subtract divider.
- Owns its own 5-bit iteration counter and a start/ready handshake toward the multdiv control, so the CPU stall logic only watches `ready`.
- Produces the low 32 bits of the product and an overflow exception flag.

Parameters:
- WIDTH, 32, operand and result width. Counter width is log2(WIDTH). Only 32 is verified.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low
- ctrl  input  1  start strobe, sampled on rising edge
- A  input  32  multiplicand, two's complement; sampled only on the start edge
- B  input  32  multiplier, two's complement; sampled only on the start edge
- result  output  32  low 32 bits of A*B
- exception  output  1  signed overflow: product does not fit in 32 bits
- ready  output  1  one-cycle pulse; result and exception are valid in this cycle
- busy  output  1  high while iterating

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, ct=0; accumulator, operand copies, result, exception, ready and busy all 0.
  - Reset asserted mid-operation aborts the operation immediately. No ready pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - ctrl=1 at an edge latches the operands as magnitudes: |A| into mcand (zero-extended to 64 bits) and |B| into mplier (32 bits).
  - Same edge latches neg = A[31]^B[31], clears the 64-bit accumulator, sets ct=0 and enters RUN.
  - |-2^31| = 0x80000000 as an unsigned magnitude.
- RUN, one iteration per cycle:
  - If mplier[0]=1, acc <= acc + mcand (64-bit add, carry discarded).
  - mcand <= mcand<<1; mplier <= mplier>>1; ct <= ct+1.
  - After the iteration with ct=31, go to DONE. Exactly 32 RUN cycles, no early termination.
  - ctrl is ignored during RUN. Operand inputs may change freely.
- Entry to DONE (same edge as the last iteration):
  - prod = neg ? (~acc+1) : acc, computed on the final acc value.
  - result <= prod[31:0].
  - exception <= 1 unless prod[63:31] is all zeros or all ones.
  - A zero product gives exception=0, whatever neg is.
- DONE (one cycle):
  - ready=1, busy=0.
  - ctrl=1 in this cycle starts a new operation (DONE->RUN, operands latched as in IDLE). Otherwise DONE->IDLE.
  - If ctrl=1 in DONE, result and exception keep the old values until the new DONE entry.
- Latency: ctrl sampled at edge N gives ready high in the cycle after edge N+32, i.e. 33 edges from start to ready.
- busy=1 in RUN only.
- result and exception hold their last values in IDLE until the next DONE entry. They never change mid-RUN.
- Throughput: one multiply per 33 cycles with back-to-back starts.
- All registers are on one clock domain. Outputs are registered. No combinational path from ctrl or A/B to any output.

Test Plan:
- Reset, then ctrl pulse with A=3, B=5 -> busy high for 32 cycles; ready pulses exactly at edge+33; result=15, exception=0.
- A=-7 (0xFFFFFFF9), B=6 -> result=0xFFFFFFD6 (-42), exception=0. Repeat with A=0, B=-1 -> result=0, exception=0.
- A=0x00010000, B=0x00010000 -> result=0, exception=1. A=0x7FFFFFFF, B=2 -> result=0xFFFFFFFE, exception=1.
- A=0x80000000, B=1 -> result=0x80000000, exception=0. A=0x80000000, B=-1 -> result=0x80000000, exception=1.
- Protocol:
  - ctrl held high and A/B toggled through all of RUN -> no restart; the original product is reported.
  - ctrl asserted in the DONE cycle with A=2, B=3 -> second ready exactly 33 edges later with result=6.
- Assert rst low at ct=10 of an operation, release 2 cycles later -> all outputs 0, no ready pulse. A fresh 4*4 completes with result=16.
